// File: rtl/rv32i_types.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rv32i_types : shared types and constants for the memory subsystem           |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
package rv32i_types;

  localparam int PMEM_LINE_W = 256;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RECOVER = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rr_select : first active port at or above rr_ptr, wrapping to the lowest    |
// | Revision  : 1.0                                                             |
// +-----------------------------------------------------------------------------+
module rr_select #(
  parameter int N_PORTS = 2,
  localparam int IDX_W  = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] active,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             w_found_hi;
  logic [IDX_W-1:0] w_idx_hi;
  logic [IDX_W-1:0] w_idx_lo;

  // Descending scans leave the lowest matching index in each candidate.
  always_comb begin
    w_found_hi = 1'b0;
    w_idx_hi   = '0;
    w_idx_lo   = '0;
    for (int j = N_PORTS - 1; j >= 0; j--) begin
      if (active[j]) begin
        w_idx_lo = IDX_W'(j);
        if (IDX_W'(j) >= rr_ptr) begin
          w_found_hi = 1'b1;
          w_idx_hi   = IDX_W'(j);
        end
      end
    end
  end

  assign grant_valid = |active;
  assign grant_idx   = w_found_hi ? w_idx_hi : w_idx_lo;

endmodule
`default_nettype wire

// File: rtl/pmem_arbiter_rr.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pmem_arbiter_rr : N-port round-robin line arbiter with response timeout     |
// | Revision        : 1.0                                                       |
// +-----------------------------------------------------------------------------+
module pmem_arbiter_rr
  import rv32i_types::*;
#(
  parameter int N_PORTS        = 2,
  parameter int LINE_W         = PMEM_LINE_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_PORTS-1:0]      req_read,
  input  logic [N_PORTS-1:0]      req_write,
  input  logic [N_PORTS*32-1:0]   req_address,
  input  logic [N_PORTS*LINE_W-1:0] req_wdata,
  output logic [N_PORTS-1:0]      req_resp,
  output logic [N_PORTS-1:0]      req_error,
  output logic [LINE_W-1:0]       req_rdata,
  input  logic                    pmem_resp,
  input  logic                    pmem_error,
  input  logic [LINE_W-1:0]       pmem_rdata,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [31:0]             pmem_address,
  output logic [LINE_W-1:0]       pmem_wdata
);

  localparam int IDX_W = $clog2(N_PORTS);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_pmem_read;
  logic             r_pmem_write;
  logic [31:0]      r_pmem_address;
  logic [LINE_W-1:0] r_pmem_wdata;

  logic             w_grant_valid;
  logic [IDX_W-1:0] w_grant_idx;
  logic [31:0]      w_sel_address;
  logic [LINE_W-1:0] w_sel_wdata;
  logic             w_sel_write;
  logic             w_mem_done;
  logic             w_timeout;
  logic             w_done;
  logic             w_err;
  logic [IDX_W-1:0] w_next_ptr;

  rr_select #(
    .N_PORTS(N_PORTS)
  ) u_rr_select (
    .active     (req_read | req_write),
    .rr_ptr     (r_rr_ptr),
    .grant_valid(w_grant_valid),
    .grant_idx  (w_grant_idx)
  );

  always_comb begin
    w_sel_address = '0;
    w_sel_wdata   = '0;
    w_sel_write   = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_sel_address = req_address[32*i +: 32];
        w_sel_wdata   = req_wdata[LINE_W*i +: LINE_W];
        w_sel_write   = req_write[i];
      end
    end
  end

  assign w_mem_done = pmem_resp | pmem_error;
  assign w_done     = (r_state == ARB_BUSY) && (w_mem_done || w_timeout);
  assign w_err      = pmem_error | w_timeout;
  assign w_next_ptr = (r_grant_idx == IDX_W'(N_PORTS - 1)) ? '0 : r_grant_idx + 1'b1;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      logic [CNT_W-1:0] r_count;

      // Held at zero outside BUSY, so every transaction starts a fresh count.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_count <= '0;
        end else if (r_state != ARB_BUSY) begin
          r_count <= '0;
        end else if (!w_mem_done) begin
          r_count <= r_count + 1'b1;
        end
      end

      assign w_timeout = (r_state == ARB_BUSY) && !w_mem_done &&
                         (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ARB_IDLE;
      r_rr_ptr       <= '0;
      r_grant_idx    <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_valid) begin
            r_grant_idx    <= w_grant_idx;
            r_pmem_address <= w_sel_address;
            r_pmem_wdata   <= w_sel_wdata;
            r_pmem_write   <= w_sel_write;
            r_pmem_read    <= !w_sel_write;
            r_state        <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (w_done) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_rr_ptr     <= w_next_ptr;
            r_state      <= ARB_RECOVER;
          end
        end
        ARB_RECOVER: r_state <= ARB_IDLE;
        default:     r_state <= ARB_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_resp
      assign req_resp[gi]  = w_done && (r_grant_idx == IDX_W'(gi));
      assign req_error[gi] = w_done && w_err && (r_grant_idx == IDX_W'(gi));
    end
  endgenerate

  assign req_rdata    = pmem_rdata;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter_rr.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_pmem_arbiter_rr : cycle-vector bench for N=2 plus a reset case for N=4   |
// | Revision           : 1.0                                                    |
// +-----------------------------------------------------------------------------+
module tb_pmem_arbiter_rr;

  localparam logic [31:0]  A0 = 32'h0000_1000;
  localparam logic [31:0]  A1 = 32'h0000_2020;
  localparam logic [255:0] WD0 = {8{32'h0A0A_0A0A}};
  localparam logic [255:0] WX  = {8{32'h1111_1111}};
  localparam logic [255:0] WY  = {8{32'h2222_2222}};
  localparam logic [255:0] LAA = {32{8'hAA}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=2 instance
  logic         rst2;
  logic [1:0]   req_read2, req_write2, req_resp2, req_error2;
  logic [63:0]  req_address2;
  logic [511:0] req_wdata2;
  logic [255:0] req_rdata2, pmem_rdata2, pmem_wdata2;
  logic         pmem_resp2, pmem_error2, pmem_read2, pmem_write2;
  logic [31:0]  pmem_address2;
  logic         wsel;

  assign req_address2 = {A1, A0};
  assign req_wdata2   = {(wsel ? WY : WX), WD0};
  assign pmem_rdata2  = LAA;

  pmem_arbiter_rr #(.N_PORTS(2), .LINE_W(256), .TIMEOUT_CYCLES(8)) dut2 (
    .clk(clk), .rst(rst2),
    .req_read(req_read2), .req_write(req_write2), .req_address(req_address2),
    .req_wdata(req_wdata2), .req_resp(req_resp2), .req_error(req_error2),
    .req_rdata(req_rdata2), .pmem_resp(pmem_resp2), .pmem_error(pmem_error2),
    .pmem_rdata(pmem_rdata2), .pmem_read(pmem_read2), .pmem_write(pmem_write2),
    .pmem_address(pmem_address2), .pmem_wdata(pmem_wdata2)
  );

  // N=4 instance
  logic          rst4;
  logic [3:0]    req_read4, req_write4, req_resp4, req_error4;
  logic [127:0]  req_address4;
  logic [1023:0] req_wdata4;
  logic [255:0]  req_rdata4, pmem_wdata4;
  logic          pmem_resp4, pmem_error4, pmem_read4, pmem_write4;
  logic [31:0]   pmem_address4;

  assign req_address4 = {32'h0000_4300, 32'h0000_4200, 32'h0000_4100, 32'h0000_4000};
  assign req_wdata4   = {4{WX}};

  pmem_arbiter_rr #(.N_PORTS(4), .LINE_W(256), .TIMEOUT_CYCLES(8)) dut4 (
    .clk(clk), .rst(rst4),
    .req_read(req_read4), .req_write(req_write4), .req_address(req_address4),
    .req_wdata(req_wdata4), .req_resp(req_resp4), .req_error(req_error4),
    .req_rdata(req_rdata4), .pmem_resp(pmem_resp4), .pmem_error(pmem_error4),
    .pmem_rdata(LAA), .pmem_read(pmem_read4), .pmem_write(pmem_write4),
    .pmem_address(pmem_address4), .pmem_wdata(pmem_wdata4)
  );

  typedef struct {
    logic [1:0]   rd, wr;
    logic         presp, perr, ws;
    logic         e_rd, e_wr;
    logic [31:0]  e_addr;
    logic [1:0]   e_resp, e_err;
    logic [255:0] e_wd;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic void add(input logic [1:0] rd, input logic [1:0] wr,
                              input logic presp, input logic perr, input logic ws,
                              input logic erd, input logic ewr, input logic [31:0] eaddr,
                              input logic [1:0] eresp, input logic [1:0] eerr,
                              input logic [255:0] ewd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.presp = presp; v.perr = perr; v.ws = ws;
    v.e_rd = erd; v.e_wr = ewr; v.e_addr = eaddr;
    v.e_resp = eresp; v.e_err = eerr; v.e_wd = ewd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input bit ok, input string detail);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst2 = 1'b1; rst4 = 1'b1; wsel = 1'b0;
    req_read2 = '0; req_write2 = '0; pmem_resp2 = 1'b0; pmem_error2 = 1'b0;
    req_read4 = '0; req_write4 = '0; pmem_resp4 = 1'b0; pmem_error4 = 1'b0;

    // Contention from reset: 0, then 1, then 0 again
    add(2'b11, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b11, 2'b00, 0, 0, 0, 1, 0, A0, 2'b00, 2'b00, '0);
    add(2'b11, 2'b00, 1, 0, 0, 1, 0, A0, 2'b01, 2'b00, '0);
    add(2'b11, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b11, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b11, 2'b00, 0, 0, 0, 1, 0, A1, 2'b00, 2'b00, '0);
    add(2'b11, 2'b00, 1, 0, 0, 1, 0, A1, 2'b10, 2'b00, '0);
    add(2'b11, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b11, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b11, 2'b00, 1, 0, 0, 1, 0, A0, 2'b01, 2'b00, '0);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    // Single read, memory answers on the 4th busy cycle
    add(2'b01, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    for (int k = 0; k < 3; k++) add(2'b01, 2'b00, 0, 0, 0, 1, 0, A0, 2'b00, 2'b00, '0);
    add(2'b01, 2'b00, 1, 0, 0, 1, 0, A0, 2'b01, 2'b00, '0);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    // Port 1 write, wdata changes X->Y mid-transaction, port 0 pokes during BUSY
    add(2'b00, 2'b10, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b00, 2'b10, 0, 0, 1, 0, 1, A1, 2'b00, 2'b00, WX);
    add(2'b01, 2'b10, 0, 0, 1, 0, 1, A1, 2'b00, 2'b00, WX);
    add(2'b00, 2'b10, 1, 0, 1, 0, 1, A1, 2'b10, 2'b00, WX);
    add(2'b00, 2'b00, 0, 0, 1, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b00, 2'b00, 0, 0, 1, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b00, 2'b00, 0, 0, 1, 0, 0, 0,  2'b00, 2'b00, '0);
    // Error on port 1 read, then port 0 wins the next contention
    add(2'b10, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b10, 2'b00, 0, 0, 0, 1, 0, A1, 2'b00, 2'b00, '0);
    add(2'b10, 2'b00, 0, 1, 0, 1, 0, A1, 2'b10, 2'b10, '0);
    add(2'b11, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b11, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b11, 2'b00, 0, 0, 0, 1, 0, A0, 2'b00, 2'b00, '0);
    add(2'b00, 2'b00, 1, 0, 0, 1, 0, A0, 2'b01, 2'b00, '0);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    // Timeout after 8 busy cycles; late resp in RECOVER/IDLE ignored
    add(2'b01, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    for (int k = 0; k < 7; k++) add(2'b01, 2'b00, 0, 0, 0, 1, 0, A0, 2'b00, 2'b00, '0);
    add(2'b01, 2'b00, 0, 0, 0, 1, 0, A0, 2'b01, 2'b01, '0);
    add(2'b00, 2'b00, 1, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b00, 2'b00, 1, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    // Read and write together resolve to a write
    add(2'b01, 2'b01, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);
    add(2'b01, 2'b01, 1, 0, 0, 0, 1, A0, 2'b01, 2'b00, WD0);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, '0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset2", pmem_read2 === 1'b0 && pmem_write2 === 1'b0 && pmem_address2 === 32'h0 &&
          pmem_wdata2 === '0 && req_resp2 === 2'b00 && req_error2 === 2'b00,
          $sformatf("got rd=%b wr=%b addr=%h resp=%b err=%b, want all zero",
                    pmem_read2, pmem_write2, pmem_address2, req_resp2, req_error2));
    @(negedge clk);
    rst2 = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      req_read2 = vecs[i].rd; req_write2 = vecs[i].wr;
      pmem_resp2 = vecs[i].presp; pmem_error2 = vecs[i].perr; wsel = vecs[i].ws;
      #1;
      ok = (pmem_read2 === vecs[i].e_rd) && (pmem_write2 === vecs[i].e_wr) &&
           (req_resp2 === vecs[i].e_resp) && (req_error2 === vecs[i].e_err) &&
           (req_rdata2 === LAA) &&
           (!(vecs[i].e_rd || vecs[i].e_wr) || pmem_address2 === vecs[i].e_addr) &&
           (!vecs[i].e_wr || pmem_wdata2 === vecs[i].e_wd);
      check($sformatf("vec%0d", i), ok,
            $sformatf("got rd=%b wr=%b addr=%h resp=%b err=%b wd=%h, want rd=%b wr=%b addr=%h resp=%b err=%b wd=%h",
                      pmem_read2, pmem_write2, pmem_address2, req_resp2, req_error2, pmem_wdata2[31:0],
                      vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_addr, vecs[i].e_resp, vecs[i].e_err,
                      vecs[i].e_wd[31:0]));
    end

    // N=4: reset asserted during a port 3 read
    @(negedge clk);
    rst4 = 1'b0; req_read4 = 4'b1000;
    #1;
    check("n4_idle", pmem_read4 === 1'b0, $sformatf("got rd=%b, want 0", pmem_read4));
    @(negedge clk); #1;
    check("n4_grant3", pmem_read4 === 1'b1 && pmem_address4 === 32'h0000_4300,
          $sformatf("got rd=%b addr=%h, want 1 00004300", pmem_read4, pmem_address4));
    #1 rst4 = 1'b1; pmem_resp4 = 1'b1;
    #1;
    check("n4_async_rst", pmem_read4 === 1'b0 && pmem_write4 === 1'b0 && pmem_address4 === 32'h0 &&
          pmem_wdata4 === '0 && req_resp4 === 4'b0000 && req_error4 === 4'b0000,
          $sformatf("got rd=%b wr=%b addr=%h resp=%b err=%b, want all zero",
                    pmem_read4, pmem_write4, pmem_address4, req_resp4, req_error4));
    @(negedge clk); #1;
    check("n4_no_resp", req_resp4 === 4'b0000 && pmem_read4 === 1'b0,
          $sformatf("got resp=%b rd=%b, want 0000 0", req_resp4, pmem_read4));
    @(negedge clk);
    rst4 = 1'b0; pmem_resp4 = 1'b0; req_read4 = 4'b1111;
    #1;
    check("n4_post_rst_idle", pmem_read4 === 1'b0, $sformatf("got rd=%b, want 0", pmem_read4));
    @(negedge clk); #1;
    check("n4_first_grant", pmem_read4 === 1'b1 && pmem_address4 === 32'h0000_4000,
          $sformatf("got rd=%b addr=%h, want 1 00004000", pmem_read4, pmem_address4));
    pmem_resp4 = 1'b1;
    #1;
    check("n4_resp0", req_resp4 === 4'b0001 && req_error4 === 4'b0000,
          $sformatf("got resp=%b err=%b, want 0001 0000", req_resp4, req_error4));
    @(negedge clk);
    pmem_resp4 = 1'b0; req_read4 = 4'b0000;
    #1;
    check("n4_recover", pmem_read4 === 1'b0 && req_resp4 === 4'b0000,
          $sformatf("got rd=%b resp=%b, want 0 0000", pmem_read4, req_resp4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
